// File: rtl/miso_pack_fifo.sv
// miso_pack_fifo: multi-input single-output FIFO with sub-word packing.
// Each write compacts up to DATA_LENGTH sparse-valid lanes into a
// circular buffer. Each pop drains one entry and packs its low slice
// into a DATA_WIDTH output word. Precision modes are full, half or
// quarter width.
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous active-high reset
//   i_clear     synchronous soft clear, same effect as reset
//   i_write_en  write request; admitted only if every valid lane fits
//   i_valid     per-lane valid, DATA_LENGTH bits
//   i_data      lane data, packed [DATA_LENGTH-1:0][DATA_WIDTH-1:0]
//   i_pop_en    pop request, ignored while empty
//   i_flush     emit a partially packed word, zero-padded
//   i_p_mode    00 full, 01 half, 10 quarter, 11 full;
//               latched at the start of each group
//   o_data      packed output word (registered)
//   o_pop_valid one-cycle pulse when o_data is new
//   o_empty     count == 0
//   o_full      count == DEPTH
//   o_wr_drop   one-cycle pulse when the last write was rejected
//   o_level     registered count; present only when the macro
//               MISO_PACK_FIFO_LEVEL_EN is defined

module miso_pack_fifo #(
    parameter  int DEPTH       = 32,
    parameter  int DATA_WIDTH  = 8,
    parameter  int DATA_LENGTH = 9,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_clear,
    input  logic                                    i_write_en,
    input  logic [DATA_LENGTH-1:0]                  i_valid,
    input  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0]  i_data,
    input  logic                                    i_pop_en,
    input  logic                                    i_flush,
    input  logic [1:0]                              i_p_mode,
    output logic [DATA_WIDTH-1:0]                   o_data,
    output logic                                    o_pop_valid,
    output logic                                    o_empty,
    output logic                                    o_full,
`ifdef MISO_PACK_FIFO_LEVEL_EN
    output logic                                    o_wr_drop,
    output logic [ADDR_WIDTH:0]                     o_level
`else
    output logic                                    o_wr_drop
`endif
);

    localparam int HW = DATA_WIDTH / 2;
    localparam int QW = DATA_WIDTH / 4;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage and state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [1:0]            r_ctr;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_acc;

    // Write side
    logic [ADDR_WIDTH:0]   w_n;
    logic [ADDR_WIDTH-1:0] w_off [DATA_LENGTH];
    logic [ADDR_WIDTH:0]   w_free;
    logic                  w_wr_ok;
    logic                  w_wr_rej;

    // Pop / pack side
    logic                  w_pop;
    logic [1:0]            w_mode;
    logic [DATA_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_slice;
    logic [DATA_WIDTH-1:0] w_placed;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic                  w_last;
    logic                  w_flush;
    logic                  w_emit;
    logic                  w_clr;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    assign w_clr = i_rst || i_clear;

    // Valid-lane popcount. The running prefix gives each valid lane
    // its slot offset, which packs the lanes in ascending order.
    always_comb begin : lane_scan
        w_n = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            w_off[i] = w_n[ADDR_WIDTH-1:0];
            w_n      = w_n + {{ADDR_WIDTH{1'b0}}, i_valid[i]};
        end
    end

    // Admission uses the registered count only. A same-cycle pop does
    // not make room for the write.
    assign w_free   = LP_DEPTH - r_count;
    assign w_wr_ok  = i_write_en && (w_n <= w_free);
    assign w_wr_rej = i_write_en && !w_wr_ok;

    assign w_pop = i_pop_en && (r_count != '0);
    assign w_rd  = r_mem[r_rptr];

    // While a group is open the latched mode rules. At a group
    // boundary the live input mode applies.
    assign w_mode = (r_ctr == 2'd0) ? i_p_mode : r_mode;

    always_comb begin : pack_slice
        w_slice  = '0;
        w_placed = '0;
        w_last   = 1'b0;
        case (w_mode)
            2'b01: begin
                w_slice[HW-1:0] = w_rd[HW-1:0];
                w_placed = r_ctr[0] ? (w_slice << HW) : w_slice;
                w_last   = (r_ctr == 2'd1);
            end
            2'b10: begin
                w_slice[QW-1:0] = w_rd[QW-1:0];
                case (r_ctr)
                    2'd0:    w_placed = w_slice;
                    2'd1:    w_placed = w_slice << QW;
                    2'd2:    w_placed = w_slice << (2 * QW);
                    default: w_placed = w_slice << (3 * QW);
                endcase
                w_last = (r_ctr == 2'd3);
            end
            default: begin
                w_slice  = w_rd;
                w_placed = w_rd;
                w_last   = 1'b1;
            end
        endcase
    end

    assign w_acc_nxt = w_pop ? (r_acc | w_placed) : r_acc;

    // A flush emits only when something is actually pending. That is
    // an open group, or a pop that starts or extends one. A pop that
    // completes its word emits on its own.
    assign w_flush = i_flush
                  && ((r_ctr != 2'd0) || w_pop)
                  && !(w_pop && w_last);
    assign w_emit  = (w_pop && w_last) || w_flush;

    assign w_count_nxt = r_count
                       + (w_wr_ok ? w_n : '0)
                       - {{ADDR_WIDTH{1'b0}}, w_pop};

    // Entry storage has no reset. Clearing the pointers is enough.
    always_ff @(posedge i_clk) begin
        if (!w_clr && w_wr_ok) begin
            for (int i = 0; i < DATA_LENGTH; i++) begin
                if (i_valid[i]) begin
                    r_mem[r_wptr + w_off[i]] <= i_data[i];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_ctr       <= 2'd0;
            r_mode      <= 2'b00;
            r_acc       <= '0;
            o_data      <= '0;
            o_pop_valid <= 1'b0;
            o_wr_drop   <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_mode      <= w_mode;
            o_pop_valid <= w_emit;
            o_wr_drop   <= w_wr_rej;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + w_n[ADDR_WIDTH-1:0];
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_emit) begin
                o_data <= w_acc_nxt;
                r_ctr  <= 2'd0;
                r_acc  <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                if (w_pop) begin
                    r_ctr <= r_ctr + 2'd1;
                end
            end
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == LP_DEPTH);

`ifdef MISO_PACK_FIFO_LEVEL_EN
    assign o_level = r_count;
`endif

endmodule

// File: doc/miso_pack_fifo.md
# miso_pack_fifo

Parametrised multi-input single-output FIFO with sub-word precision packing for the sequential router's memory stage. Each cycle it accepts up to DATA_LENGTH sparse-valid lanes, compacts the valid ones into a circular buffer, and drains one entry per pop. Popped low-order slices are packed into full DATA_WIDTH output words according to the precision mode. Compared with the previous MISO FIFO, it adds:
- true full/empty accounting with all DEPTH entries usable;
- all-or-nothing write admission with a drop flag;
- per-group mode latching;
- explicit flush of partial words;
- single-cycle output pulses.

## Interface
Parameters:
- DEPTH, 32, entry count; power of two, at least DATA_LENGTH
- DATA_WIDTH, 8, entry/output word width; divisible by 4
- DATA_LENGTH, 9, input lanes per write
- ADDR_WIDTH, $clog2(DEPTH), localparam pointer width

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_clear  in  1  synchronous soft clear, same effect as reset
- i_write_en  in  1  write request
- i_valid  in  DATA_LENGTH  per-lane valid
- i_data  in  DATA_LENGTH×DATA_WIDTH  lane data, packed array
- i_pop_en  in  1  pop request
- i_flush  in  1  emit a partially packed word
- i_p_mode  in  2  00 full-width, 01 half (DATA_WIDTH/2 slices), 10 quarter (DATA_WIDTH/4 slices), 11 treated as 00
- o_data  out  DATA_WIDTH  packed output word
- o_pop_valid  out  1  one-cycle pulse: o_data is new
- o_empty  out  1  count == 0
- o_full  out  1  count == DEPTH
- o_wr_drop  out  1  one-cycle pulse: last write rejected

## Operation
State registers:
- w_ptr, r_ptr: ADDR_WIDTH bits each, wrap modulo DEPTH.
- count: ADDR_WIDTH+1 bits.
- Packing counter ctr: 2 bits.
- Latched group mode: 2 bits.
- Accumulator acc: DATA_WIDTH bits.

Priority: i_rst > i_clear > normal operation.
- On reset or clear: pointers, count, ctr, and acc go to 0; latched mode goes to 00; all outputs take their reset values.
- FIFO contents are not cleared.

Write:
- Let n = popcount(i_valid). The write is accepted when i_write_en=1 and n ≤ DEPTH − count, where count is the registered value. There is no same-cycle pop bypass.
- On acceptance, valid lanes are stored in ascending lane order at w_ptr, w_ptr+1, … (mod DEPTH), and w_ptr advances by n.
- If n = 0, an asserted i_write_en is accepted as a no-op.
- On rejection, nothing is stored and o_wr_drop pulses for the next cycle.

Pop:
- A pop occurs when i_pop_en=1 and count ≠ 0. It reads fifo[r_ptr] and increments r_ptr.
- If i_pop_en=1 while the FIFO is empty, nothing happens and no stale output is produced.
- count_next = count + accepted n − (pop ? 1 : 0).

Packing:
- When ctr == 0, the current i_p_mode is latched for the group. Changes to i_p_mode while ctr ≠ 0 are ignored until the group ends.
- Ratio R is 1, 2, or 4; slice width SW = DATA_WIDTH/R.
- Each pop places entry[SW−1:0] at acc[ctr·SW +: SW] and increments ctr.
- When the popped slice is slice R−1:
  - o_data is loaded with the complete word;
  - o_pop_valid pulses;
  - ctr and acc are cleared.
- Slice 0 occupies the LSBs.

Flush:
- i_flush=1 with ctr ≠ 0, or with a same-cycle pop that would leave ctr ≠ 0: o_data is loaded with acc (including any same-cycle popped slice), upper slices are zero-padded, o_pop_valid pulses, and ctr and acc are cleared.
- i_flush=1 with ctr == 0 and no pop: no effect.

## Timing
- Reset values: o_data = 0, o_pop_valid = 0, o_empty = 1, o_full = 0, o_wr_drop = 0.
- o_empty and o_full are combinational from the registered count. They reflect a write or pop on the cycle after its clock edge.
- Write-to-pop latency: an entry written at edge N can be popped by a pop request sampled at edge N+1.
- Output latency: o_data and o_pop_valid are registered and appear in the cycle after the completing pop or flush edge.
- Steady-state output rate: one word per 1, 2, or 4 pops. o_pop_valid is never high for two cycles unless words complete on consecutive pops.
- Simultaneous full write and pop when count = DEPTH: the write is rejected and the pop proceeds. Callers retry the write.
- Reset mid-group discards the partial accumulator with no output.

## Configuration
- MISO_PACK_FIFO_LEVEL_EN defined: adds output port o_level [ADDR_WIDTH:0], equal to the registered count, reset value 0.
- MISO_PACK_FIFO_LEVEL_EN undefined: the port is absent. Internal count and all other behaviour are identical.

## Test plan
- Sparse write compaction: reset, then write i_valid=9'b100000101 with lanes 0, 2, 8 = 0x11, 0x22, 0x33; pop ×3 in mode 00. Expect o_data 0x11, 0x22, 0x33, each with a one-cycle o_pop_valid, then o_empty=1.
- Half-width packing: mode 01, push 0xA5, 0x3C, then pop ×2. Expect a single o_data=0xC5 pulse after the second pop.
- Quarter-width packing with flush: mode 10, push 0x01, 0x02, 0x03, pop ×3, then i_flush. Expect o_data=0x39 (upper slice zero) with one pulse; ctr returns to 0.
- Full boundary and drop: DEPTH=32, fill to 30 entries, then write 3 valid lanes. Expect o_wr_drop pulse and count stays 30. Write 2 lanes: expect o_full=1 on the next cycle. A further pop then lowers count to 31 and clears o_full.
- Wrap-around with concurrent write and pop: run 100 cycles of random concurrent writes and pops. Expect output order to match a scoreboard, count to never exceed 32, and no pop while empty to produce o_pop_valid.
- Clear mid-group: mode 10 after 2 pops, assert i_clear. Expect no output, o_empty=1, and the next group starting at slice 0.
